tmds_decode_align: RTL and testbench



---
 rtl/tmds_pkg.sv | 49 ++++
 rtl/tmds_decode_align_word_decode.sv | 60 ++++++
 rtl/tmds_decode_align.sv | 139 +++++++++++++
 tb/tb_tmds_decode_align.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, align FSM states and the
// 10b->8b data decode used by the datapath.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    typedef struct packed {
        logic       is_tok;
        logic [1:0] ctl;     // {C1, C0}
    } tok_class_t;

    function automatic tok_class_t classify(input logic [9:0] q);
        tok_class_t r;
        r.is_tok = 1'b1;
        r.ctl    = 2'b00;
        case (q)
            TOK_C00: r.ctl = 2'b00;
            TOK_C01: r.ctl = 2'b01;
            TOK_C10: r.ctl = 2'b10;
            TOK_C11: r.ctl = 2'b11;
            default: r.is_tok = 1'b0;
        endcase
        return r;
    endfunction

    // q[9] undoes the encoder's inversion, q[8] selects XOR vs XNOR chaining.
    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

endpackage

// File: rtl/tmds_decode_align_word_decode.sv
// Two-stage registered datapath: stage 1 captures the word and its token
// class, stage 2 produces DE/C0/C1/pixel, zeroed whenever out_en_i is low.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] word_i,
    input  logic       out_en_i,
    output logic       s1_tok_o,
    output logic       de_o,
    output logic       c0_o,
    output logic       c1_o,
    output logic [7:0] pixel_o
);

    logic [9:0] word_q;
    tok_class_t cls_q;
    logic       de_q;
    logic       c0_q;
    logic       c1_q;
    logic [7:0] pixel_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            cls_q   <= '0;
            de_q    <= 1'b0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            pixel_q <= '0;
        end else begin
            word_q <= word_i;
            cls_q  <= classify(word_i);
            if (!out_en_i) begin
                de_q    <= 1'b0;
                c0_q    <= 1'b0;
                c1_q    <= 1'b0;
                pixel_q <= '0;
            end else if (cls_q.is_tok) begin
                de_q    <= 1'b0;
                c1_q    <= cls_q.ctl[1];
                c0_q    <= cls_q.ctl[0];
                pixel_q <= '0;
            end else begin
                de_q    <= 1'b1;
                c0_q    <= 1'b0;
                c1_q    <= 1'b0;
                pixel_q <= tmds_decode(word_q);
            end
        end
    end

    assign s1_tok_o = cls_q.is_tok;
    assign de_o     = de_q;
    assign c0_o     = c0_q;
    assign c1_o     = c1_q;
    assign pixel_o  = pixel_q;

endmodule

// File: rtl/tmds_decode_align.sv
// TMDS channel receiver: bit-slip word alignment on control tokens, then
// 2-cycle decode to pixel byte or C0/C1 with DE. O_Dbg_State exposes the FSM.
module tmds_decode_align
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16
) (
    input  logic       Pixl_CLK,
    input  logic       Rst_Posedge,
    input  logic [9:0] I_Tmds_Word,
    output logic       O_Bitslip,
    output logic       O_Locked,
    output logic [3:0] O_Slip_Cnt,
    output logic       O_VGA_De,
    output logic       O_C0,
    output logic       O_C1,
    output logic [7:0] O_Pixel_Data,
    output logic [1:0] O_Dbg_State
);

    localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
    localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam logic [TOK_W-1:0]  TOK_MAX   = TOK_W'(LOCK_TOKENS);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SEARCH_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    state_t            state_q;
    logic [TOK_W-1:0]  tok_cnt_q;
    logic [TOK_W-1:0]  tok_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [3:0]        slip_cnt_q;
    logic [3:0]        slip_cnt_d;
    logic              bitslip_q;
    logic              locked_q;
    logic              locked_d;
    logic              lock_hit;
    logic              timeout_hit;
    logic              s1_tok;

    // Lock state is decided on the stage-1 word so it lands on the same edge
    // as that word's stage-2 output.
    tmds_word_decode u_dec (
        .clk_i    (Pixl_CLK),
        .rst_i    (Rst_Posedge),
        .word_i   (I_Tmds_Word),
        .out_en_i (locked_d),
        .s1_tok_o (s1_tok),
        .de_o     (O_VGA_De),
        .c0_o     (O_C0),
        .c1_o     (O_C1),
        .pixel_o  (O_Pixel_Data)
    );

    always_comb begin
        tok_cnt_d  = '0;
        idle_cnt_d = '0;
        if (s1_tok) begin
            tok_cnt_d = (tok_cnt_q == TOK_MAX) ? tok_cnt_q : tok_cnt_q + TOK_W'(1);
        end else begin
            idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        end
        lock_hit    = (state_q == ST_SEARCH) && (tok_cnt_d == TOK_MAX);
        timeout_hit = ((state_q == ST_SEARCH) || (state_q == ST_LOCKED)) &&
                      (idle_cnt_d == IDLE_MAX);
        locked_d    = lock_hit || ((state_q == ST_LOCKED) && !timeout_hit);
        slip_cnt_d  = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
    end

    // O_Bitslip is a one-shot request with no acknowledge: the deserializer
    // takes it on the cycle it is high, and WAIT covers its settling time.
    always_ff @(posedge Pixl_CLK) begin
        if (Rst_Posedge) begin
            state_q    <= ST_SEARCH;
            tok_cnt_q  <= '0;
            idle_cnt_q <= '0;
            wait_cnt_q <= '0;
            slip_cnt_q <= '0;
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            locked_q  <= locked_d;
            case (state_q)
                ST_SEARCH: begin
                    if (lock_hit) begin
                        state_q    <= ST_LOCKED;
                        slip_cnt_q <= '0;
                        tok_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                    end else if (timeout_hit) begin
                        state_q    <= ST_SLIP;
                        bitslip_q  <= 1'b1;
                        slip_cnt_q <= slip_cnt_d;
                        tok_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                    end else begin
                        tok_cnt_q  <= tok_cnt_d;
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                ST_SLIP: begin
                    state_q    <= ST_WAIT;
                    wait_cnt_q <= '0;
                end
                ST_WAIT: begin
                    tok_cnt_q  <= '0;
                    idle_cnt_q <= '0;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_SEARCH;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (timeout_hit) begin
                        state_q    <= ST_SLIP;
                        bitslip_q  <= 1'b1;
                        slip_cnt_q <= slip_cnt_d;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

    assign O_Bitslip   = bitslip_q;
    assign O_Locked    = locked_q;
    assign O_Slip_Cnt  = slip_cnt_q;
    assign O_Dbg_State = state_q;

endmodule

// File: tb/tb_tmds_decode_align.sv
// Bench for tmds_decode_align: deserializer model with bit rotation, a
// spec-level decode model feeding an expected queue, and scenario tasks.
`timescale 1ns/1ps
module tb_tmds_decode_align;
    import tmds_pkg::*;

    localparam int LOCK_TOKENS    = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int SLIP_WAIT      = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] word = '0;
    logic       bitslip;
    logic       locked;
    logic [3:0] slip_cnt;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] pix;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int rot = 0;

    logic [11:0] exp_q[$];
    logic [11:0] exp_now = '0;
    logic [9:0]  tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    tmds_decode_align #(
        .LOCK_TOKENS    (LOCK_TOKENS),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) dut (
        .Pixl_CLK     (clk),
        .Rst_Posedge  (rst),
        .I_Tmds_Word  (word),
        .O_Bitslip    (bitslip),
        .O_Locked     (locked),
        .O_Slip_Cnt   (slip_cnt),
        .O_VGA_De     (de),
        .O_C0         (c0),
        .O_C1         (c1),
        .O_Pixel_Data (pix),
        .O_Dbg_State  (dbg_state)
    );

    // ---------------- reference model ----------------
    // Expected {locked, de, c1, c0, pixel} for a word seen while aligned.
    function automatic logic [11:0] model_out(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] p;
        for (int c = 0; c < 4; c++) begin
            if (w == tok_tab[c]) return {1'b1, 1'b0, 2'(c), 8'h00};
        end
        d = w[7:0] ^ {8{w[9]}};
        p = d ^ (d << 1) ^ (w[8] ? 8'h00 : 8'hFE);
        return {1'b1, 1'b1, 2'b00, p};
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        for (int c = 0; c < 4; c++) begin
            if (w == tok_tab[c]) w = w ^ 10'h001;
        end
        return w;
    endfunction

    function automatic logic [11:0] get_obs();
        return {locked, de, c1, c0, pix};
    endfunction

    // ---------------- driver ----------------
    // Applies w rotated by the current misalignment; the sample taken at the
    // following negedge reflects the word driven two calls earlier.
    task automatic drive(input logic [9:0] w, input logic r);
        logic [19:0] ww;
        @(posedge clk);
        #1;
        if (r) rot = 0;
        ww   = {w, w} >> rot;
        word = ww[9:0];
        rst  = r;
        exp_q.push_back(model_out(ww[9:0]));
        if (exp_q.size() >= 3) exp_now = exp_q.pop_front();
        @(negedge clk);
        if (bitslip === 1'b1) rot = (rot + 9) % 10;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(10'($urandom_range(0, 1023)), 1'b1);
            n_checks++;
            if ({locked, bitslip, slip_cnt, de, c1, c0, pix} !== 17'h0) begin
                n_errors++;
                $display("FAIL reset_outputs: got %h expected 0",
                         {locked, bitslip, slip_cnt, de, c1, c0, pix});
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(rand_data(), 1'b0);
            n_checks++;
            if ({locked, bitslip, slip_cnt, de, pix} !== 15'h0 || dbg_state !== ST_SEARCH) begin
                n_errors++;
                $display("FAIL post_reset: got out=%h state=%0d expected out=0 state=%0d",
                         {locked, bitslip, slip_cnt, de, pix}, dbg_state, ST_SEARCH);
            end
        end
    endtask

    task automatic test_lock_decode();
        logic [9:0] seq [13];
        for (int i = 0; i < 8; i++) seq[i] = tok_tab[0];
        seq[8]  = 10'h100;
        seq[9]  = 10'h1FF;
        seq[10] = 10'h2FF;
        seq[11] = tok_tab[0];
        seq[12] = tok_tab[0];
        for (int i = 0; i < 13; i++) begin
            drive(seq[i], 1'b0);
            if (i == 8) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL lock_early: got locked=%b expected 0", locked);
                end
            end
            if (i == 9) begin
                n_checks++;
                if (get_obs() !== 12'h800 || slip_cnt !== 4'd0) begin
                    n_errors++;
                    $display("FAIL lock_rise: got %h slip=%0d expected 800 slip=0",
                             get_obs(), slip_cnt);
                end
            end
            if (i >= 10 && i <= 12) begin
                logic [11:0] e;
                e = (i == 10) ? 12'hC00 : (i == 11) ? 12'hC01 : 12'hCFE;
                n_checks++;
                if (get_obs() !== e) begin
                    n_errors++;
                    $display("FAIL data_decode[%0d]: got %h expected %h", i - 10, get_obs(), e);
                end
            end
        end
    endtask

    task automatic test_control_decode();
        logic [9:0] seq [4];
        seq[0] = tok_tab[2];
        seq[1] = tok_tab[3];
        seq[2] = tok_tab[0];
        seq[3] = tok_tab[0];
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], 1'b0);
            if (i >= 2) begin
                logic [11:0] e;
                e = (i == 2) ? 12'hA00 : 12'hB00;
                n_checks++;
                if (get_obs() !== e) begin
                    n_errors++;
                    $display("FAIL ctrl_decode[%0d]: got %h expected %h", i - 2, get_obs(), e);
                end
            end
        end
    endtask

    task automatic test_random_locked();
        for (int i = 0; i < 160; i++) begin
            if (i % 8 == 0) drive(tok_tab[$urandom_range(0, 3)], 1'b0);
            else            drive(10'($urandom_range(0, 1023)), 1'b0);
            n_checks++;
            if (get_obs() !== exp_now || bitslip !== 1'b0) begin
                n_errors++;
                $display("FAIL random_decode[%0d]: got %h slip=%b expected %h slip=0",
                         i, get_obs(), bitslip, exp_now);
            end
        end
    endtask

    task automatic test_lock_loss();
        // Token on the 64th word keeps lock.
        for (int i = 0; i < 67; i++) begin
            drive((i == 0 || i >= 64) ? tok_tab[0] : rand_data(), 1'b0);
            n_checks++;
            if (get_obs() !== exp_now || bitslip !== 1'b0) begin
                n_errors++;
                $display("FAIL keep_lock[%0d]: got %h slip=%b expected %h slip=0",
                         i, get_obs(), bitslip, exp_now);
            end
        end
        // 64 data words in a row drop lock.
        for (int i = 0; i < 67; i++) begin
            drive((i < 64) ? rand_data() : tok_tab[0], 1'b0);
            if (i <= 64) begin
                n_checks++;
                if (get_obs() !== exp_now || bitslip !== 1'b0) begin
                    n_errors++;
                    $display("FAIL pre_loss[%0d]: got %h slip=%b expected %h slip=0",
                             i, get_obs(), bitslip, exp_now);
                end
            end
            if (i == 65) begin
                n_checks++;
                if ({locked, bitslip, slip_cnt, de, c1, c0, pix} !== {1'b0, 1'b1, 4'd1, 11'h0}) begin
                    n_errors++;
                    $display("FAIL lock_loss: got %h expected %h",
                             {locked, bitslip, slip_cnt, de, c1, c0, pix},
                             {1'b0, 1'b1, 4'd1, 11'h0});
                end
            end
            if (i == 66) begin
                n_checks++;
                if (bitslip !== 1'b0 || get_obs() !== 12'h000) begin
                    n_errors++;
                    $display("FAIL slip_single: got slip=%b out=%h expected slip=0 out=000",
                             bitslip, get_obs());
                end
            end
        end
    endtask

    task automatic test_reset_wait();
        drive(tok_tab[0], 1'b0);
        drive(tok_tab[0], 1'b0);
        n_checks++;
        if (dbg_state !== ST_WAIT) begin
            n_errors++;
            $display("FAIL in_wait: got state=%0d expected %0d", dbg_state, ST_WAIT);
        end
        drive(tok_tab[0], 1'b1);
        for (int i = 0; i < 12; i++) begin
            drive(tok_tab[0], 1'b0);
            if (i == 0) begin
                n_checks++;
                if (dbg_state !== ST_SEARCH || bitslip !== 1'b0 || slip_cnt !== 4'd0 || locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL reset_in_wait: got state=%0d slip=%b cnt=%0d lock=%b expected %0d 0 0 0",
                             dbg_state, bitslip, slip_cnt, locked, ST_SEARCH);
                end
            end
            if (i == 8 || i == 9) begin
                n_checks++;
                if (locked !== (i == 9)) begin
                    n_errors++;
                    $display("FAIL relock[%0d]: got locked=%b expected %b", i, locked, (i == 9));
                end
            end
        end
    endtask

    task automatic test_misalign();
        int  pulses;
        int  last;
        logic prev_bs;
        logic [3:0] prev_cnt;
        logic done;
        drive(tok_tab[0], 1'b1);
        drive(tok_tab[0], 1'b1);
        rot      = 3;
        pulses   = 0;
        last     = -1;
        prev_bs  = 1'b0;
        prev_cnt = '0;
        done     = 1'b0;
        for (int i = 0; i < 1500 && !done; i++) begin
            drive(tok_tab[0], 1'b0);
            if (bitslip === 1'b1) begin
                n_checks++;
                if (prev_bs !== 1'b0 || (last >= 0 && i - last < SLIP_WAIT + 1) ||
                    slip_cnt !== 4'(pulses + 1)) begin
                    n_errors++;
                    $display("FAIL slip_pulse[%0d]: prev=%b gap=%0d cnt=%0d expected prev=0 gap>=%0d cnt=%0d",
                             pulses, prev_bs, i - last, slip_cnt, SLIP_WAIT + 1, pulses + 1);
                end
                pulses++;
                last = i;
            end
            if (locked === 1'b1) begin
                done = 1'b1;
                n_checks++;
                if (pulses != 3 || prev_cnt !== 4'd3 || slip_cnt !== 4'd0) begin
                    n_errors++;
                    $display("FAIL misalign_lock: got pulses=%0d cnt_before=%0d cnt=%0d expected 3 3 0",
                             pulses, prev_cnt, slip_cnt);
                end
            end
            prev_bs  = bitslip;
            prev_cnt = slip_cnt;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL misalign_timeout: got no lock after 1500 cycles expected lock");
        end
    endtask

    // ---------------- sequence / final report ----------------
    initial begin
        test_reset();
        test_lock_decode();
        test_control_decode();
        test_random_locked();
        test_lock_loss();
        test_reset_wait();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
